// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: the 2-bit FSM state
// encoding and the default RAM geometry / CPU base address.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    // Loader FSM states
    localparam logic [1:0] ST_HDR  = 2'd0;  // collecting the 4-byte word count
    localparam logic [1:0] ST_DATA = 2'd1;  // collecting program words
    localparam logic [1:0] ST_RUN  = 2'd2;  // program loaded, CPU released
    localparam logic [1:0] ST_ERR  = 2'd3;  // header count too large

    localparam int          DEFAULT_DEPTH     = 1024;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

endpackage

// File: rtl/imem_ram.sv
// ---------------------------------------------------------------------------
// imem_ram
// Instruction RAM, DEPTH x 32 bits. One synchronous write port, one
// asynchronous (same-cycle) read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : read data (combinational)
// ---------------------------------------------------------------------------
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a byte stream (4-byte little-endian word count N, then N
// little-endian words), writes the words into the instruction RAM, then
// releases the CPU from reset and serves instruction fetches.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : load-stream byte
//   in_valid   : in_data is valid
//   in_ready   : byte accepted this cycle (HDR/DATA only)
//   instr_addr : CPU fetch byte address
//   instr      : instruction at instr_addr, 0 when out of range or not running
//   cpu_rst    : reset to the CPU, held until the load completes
//   load_done  : program loaded, CPU running
//   load_err   : header count exceeded DEPTH
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH) << 2;   // mapped bytes

    logic [1:0]    state, state_nxt;
    logic [1:0]    byte_cnt;
    logic [23:0]   asm_q;       // first three bytes; the fourth comes straight from in_data
    logic [AW-1:0] word_idx;
    logic [AW:0]   n_words;     // N <= DEPTH, so one extra bit suffices
    logic          fire, last_byte, ram_we;
    logic [31:0]   full_word;
    logic [31:0]   offset;
    logic          in_range;
    logic [31:0]   rdata;

    assign in_ready  = (state == ST_HDR) || (state == ST_DATA);
    assign fire      = in_valid && in_ready;
    assign last_byte = fire && (byte_cnt == 2'd3);
    assign full_word = {in_data, asm_q};

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        case (state)
            ST_HDR: begin
                if (last_byte) begin
                    if (full_word == 32'd0)               state_nxt = ST_RUN;
                    else if (full_word > 32'(DEPTH))      state_nxt = ST_ERR;
                    else                                  state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_byte) begin
                    ram_we = 1'b1;
                    if (({1'b0, word_idx} + (AW+1)'(1)) == n_words) state_nxt = ST_RUN;
                end
            end
            default: state_nxt = state;   // RUN and ERR are left only by rst
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HDR;
            byte_cnt <= 2'd0;
            asm_q    <= '0;
            word_idx <= '0;
            n_words  <= '0;
            cpu_rst  <= 1'b1;
        end else begin
            state   <= state_nxt;
            // Registered from the next state so it drops with the first RUN cycle
            cpu_rst <= (state_nxt != ST_RUN);
            if (fire) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    asm_q[7:0]   <= in_data;
                    2'd1:    asm_q[15:8]  <= in_data;
                    2'd2:    asm_q[23:16] <= in_data;
                    default: asm_q        <= '0;
                endcase
            end
            if ((state == ST_HDR) && last_byte) begin
                n_words  <= full_word[AW:0];
                word_idx <= '0;
            end
            if (ram_we) word_idx <= word_idx + AW'(1);
        end
    end

    assign load_done = (state == ST_RUN);
    assign load_err  = (state == ST_ERR);

    // Address translation; the full offset takes part in the range check,
    // bits [1:0] are dropped only for the word index.
    assign offset   = instr_addr - BASE_ADDR;
    assign in_range = (instr_addr >= BASE_ADDR) && (offset < SPAN);
    assign instr    = (load_done && in_range) ? rdata : 32'h0;

    imem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_idx),
        .wdata (full_word),
        .raddr (offset[AW+1:2]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int M_LOAD = 0, M_RUN = 1, M_ERR = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        cpu_rst, done, err, ready;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        cpu_rst, load_done, load_err;

    int   vectors = 0, miscompares = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   chk_tgl = 1'b0;

    // Reference memory image: survives rst, like the real RAM
    logic [31:0] mref  [DEPTH];
    bit          known [DEPTH];
    int          mode;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .instr_addr(instr_addr), .instr(instr),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Interpret a byte stream as a loader would: header, then whole words only.
    function automatic int model_feed(input bq_t bs);
        logic [31:0] n;
        if (bs.size() < 4) return M_LOAD;
        n = {bs[3], bs[2], bs[1], bs[0]};
        if (n == 32'd0) return M_RUN;
        if (n > 32'(DEPTH)) return M_ERR;
        for (int i = 0; i < int'(n); i++) begin
            if (4 + 4*i + 3 >= bs.size()) return M_LOAD;
            mref[i]  = {bs[4+4*i+3], bs[4+4*i+2], bs[4+4*i+1], bs[4+4*i]};
            known[i] = 1'b1;
        end
        return M_RUN;
    endfunction

    function automatic logic [31:0] exp_fetch(input logic [31:0] a, input int md);
        logic [31:0] off;
        if (md != M_RUN) return 32'h0;
        if (a < BASE) return 32'h0;
        off = a - BASE;
        if (off >= 32'(DEPTH*4)) return 32'h0;
        return mref[int'(off >> 2)];
    endfunction

    task automatic check(input string name, input logic [31:0] a, input int md);
        exp_t e;
        e.name    = name;
        e.instr   = exp_fetch(a, md);
        e.cpu_rst = (md != M_RUN);
        e.done    = (md == M_RUN);
        e.err     = (md == M_ERR);
        e.ready   = (md == M_LOAD);
        instr_addr = a;
        exp_q.push_back(e);
        chk_tgl = ~chk_tgl;
        @(negedge clk);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation
    always @(chk_tgl) begin
        #1;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL monitor: got an observation with no expectation queued");
        end else begin
            cur = exp_q.pop_front();
            if (instr !== cur.instr || cpu_rst !== cur.cpu_rst || load_done !== cur.done ||
                load_err !== cur.err || in_ready !== cur.ready) begin
                miscompares++;
                $display("FAIL %s: got instr=%h cpu_rst=%b done=%b err=%b ready=%b, want instr=%h cpu_rst=%b done=%b err=%b ready=%b",
                         cur.name, instr, cpu_rst, load_done, load_err, in_ready,
                         cur.instr, cur.cpu_rst, cur.done, cur.err, cur.ready);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int n;
        n = 0;
        if (gappy) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0; in_data = 8'($urandom);
                @(negedge clk);
            end
        end
        in_data = b; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk); n++;
        end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 20 cycles, want 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t bs, input bit gappy);
        foreach (bs[i]) send_byte(bs[i], gappy);
    endtask

    initial begin
        bq_t prog, pa, pb, hdr;
        int  n, k;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; instr_addr = BASE;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_state", BASE, M_LOAD);

        // Basic two-word load, byte by byte with cpu_rst timing
        prog = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20,
                 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 11; i++) send_byte(prog[i], 1'b0);
        mode = model_feed(prog[0:10]);
        check("before_last_byte", BASE, mode);
        send_byte(prog[11], 1'b0);
        mode = model_feed(prog);
        check("cpu_rst_fall", BASE, mode);
        check("word1", BASE + 32'd4, mode);
        check("below_base", 32'h003F_FFFC, mode);
        check("past_end", BASE + 32'(DEPTH*4), mode);
        check("unaligned", 32'h0040_0002, mode);
        repeat (4) @(negedge clk);
        check("run_hold", BASE, mode);

        // Empty program
        do_reset();
        hdr = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(hdr, 1'b0);
        mode = model_feed(hdr);
        check("empty_run", BASE, mode);
        check("empty_oob", BASE - 32'd4, mode);

        // Overflow header N = DEPTH+1
        do_reset();
        hdr = '{8'h01, 8'h04, 8'h00, 8'h00};
        send_stream(hdr, 1'b0);
        mode = model_feed(hdr);
        check("overflow", BASE, mode);
        repeat (5) @(negedge clk);
        check("overflow_hold", BASE, mode);

        // Gapped valid, same stream
        do_reset();
        send_stream(prog, 1'b1);
        mode = model_feed(prog);
        check("gapped_w0", BASE, mode);
        check("gapped_w1", BASE + 32'd4, mode);

        // Reset after 7 bytes, then a fresh program
        do_reset();
        pa = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
        send_stream(pa, 1'b0);
        mode = model_feed(pa);
        check("abort_mid", BASE, mode);
        do_reset();
        pb = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h0D, 8'hF0, 8'hAD, 8'h0B};
        send_stream(pb, 1'b0);
        mode = model_feed(pb);
        check("reload_w0", BASE, mode);
        check("reload_w1", BASE + 32'd4, mode);

        // Random programs, some preceded by an abandoned partial load
        repeat (6) begin
            do_reset();
            n = $urandom_range(1, 8);
            prog = '{8'(n), 8'h00, 8'h00, 8'h00};
            for (int i = 0; i < 4*n; i++) prog.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, prog.size() - 1);
                send_stream(prog[0:k-1], 1'b1);
                mode = model_feed(prog[0:k-1]);
                check("rand_abort", BASE, mode);
                do_reset();
            end
            send_stream(prog, 1'b1);
            mode = model_feed(prog);
            for (int j = 0; j < 3; j++)
                check("rand_fetch", BASE + 32'(4*$urandom_range(0, n-1)) + 32'($urandom_range(0, 3)), mode);
        end

        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(negedge clk); k++;
        end
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
